// File: rtl/psum_acc_mem.sv
// psum_acc_mem: partial-sum memory with read-modify-write accumulate, forwarding, ReLU reads and bulk clear
// Ports:
//   clk, reset       : clock, synchronous active-high reset (control state only)
//   in_valid/ready   : op handshake; ready only while the clear FSM is idle
//   in_mode          : 00 write, 01 accumulate, 10 read, 11 read-and-clear
//   in_addr, in_data : word address (>= num is a no-op slot) and lane operand
//   relu_en          : clamp negative lanes of the read result to 0
//   clear_start      : pulse to zero the whole array
//   out_valid/data   : read result, two cycles after the op is accepted
module psum_acc_mem #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int num     = 2048,
   parameter int addr_bw = 11,
   parameter int sat     = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_mode,
   input  logic [addr_bw-1:0]     in_addr,
   input  logic [psum_bw*col-1:0] in_data,
   input  logic                   relu_en,
   input  logic                   clear_start,
   output logic                   out_valid,
   output logic [psum_bw*col-1:0] out_data
);
   localparam int iw = num > 1 ? $clog2(num) : 1;
   localparam int w  = psum_bw * col;

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} clrStateT;

   clrStateT state, nextState;
   logic [iw-1:0] clrCnt;
   logic clrWr, clrDone, accept;

   logic [w-1:0] mem [num];
   logic [w-1:0] memQ;

   logic               s2Valid, s2Relu, s2Oor;
   logic [1:0]         s2Mode;
   logic [addr_bw-1:0] s2Addr;
   logic [w-1:0]       s2Data;

   logic               lastWrValid;
   logic [addr_bw-1:0] lastWrAddr;
   logic [w-1:0]       lastWrData;

   logic [w-1:0] oldVal, newVal, outVal;
   logic         wrEn;

   assign in_ready = state == IDLE;
   assign accept   = in_valid && in_ready;
   assign clrDone  = clrCnt == iw'(num - 1);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
      if (reset || state != CLEAR) clrCnt <= '0;
      else                         clrCnt <= clrDone ? '0 : clrCnt + iw'(1);
   end

   always_comb begin
      nextState = state;
      clrWr     = state == CLEAR;
      if (state == IDLE && clear_start) nextState = DRAIN;
      else if (state == DRAIN)          nextState = CLEAR;
      else if (state == CLEAR && clrDone) nextState = IDLE;
   end

   // Memory Q is read-before-write, so the value committed by the previous
   // S2 op is not yet visible; forward it from the last-write register.
   assign oldVal = (lastWrValid && lastWrAddr == s2Addr) ? lastWrData : memQ;
   assign wrEn   = s2Valid && !s2Oor && s2Mode != 2'b10;

   for (genvar k = 0; k < col; k++) begin : gLane
      logic [psum_bw-1:0] a, b, acc;
      logic [psum_bw:0]   s;
      assign a   = oldVal[psum_bw*k +: psum_bw];
      assign b   = s2Data[psum_bw*k +: psum_bw];
      assign s   = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      // Overflow when the two top bits of the widened sum differ; clamp toward its sign.
      assign acc = (sat != 0 && s[psum_bw] != s[psum_bw-1]) ?
                   {s[psum_bw], {(psum_bw-1){~s[psum_bw]}}} : s[psum_bw-1:0];
      assign newVal[psum_bw*k +: psum_bw] = s2Mode == 2'b00 ? b :
                                            s2Mode == 2'b01 ? acc :
                                            s2Mode == 2'b10 ? a : '0;
      assign outVal[psum_bw*k +: psum_bw] = (s2Oor || (s2Relu && a[psum_bw-1])) ? '0 : a;
   end

   always_ff @(posedge clk) begin
      memQ <= mem[in_addr[iw-1:0]];
      if (!reset && clrWr)     mem[clrCnt] <= '0;
      else if (!reset && wrEn) mem[s2Addr[iw-1:0]] <= newVal;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2Valid     <= 1'b0;
         lastWrValid <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
      end else begin
         s2Valid     <= accept;
         lastWrValid <= wrEn;
         out_valid   <= s2Valid && s2Mode[1];
         out_data    <= outVal;
      end
      s2Mode     <= in_mode;
      s2Addr     <= in_addr;
      s2Data     <= in_data;
      s2Relu     <= relu_en;
      s2Oor      <= 32'(in_addr) >= num;
      lastWrAddr <= s2Addr;
      lastWrData <= newVal;
   end
endmodule

// File: tb/tb_psum_acc_mem.sv
// tb_psum_acc_mem: saturating and wrapping instances driven in lockstep against a lane-level array model
module tb_psum_acc_mem;
   localparam int COL = 8;
   localparam int BW  = 16;
   localparam int NUM = 16;
   localparam int AW  = 5;
   localparam int W   = BW * COL;

   typedef int lanesT [COL];

   logic clk = 0, reset = 1, in_valid = 0, relu_en = 0, clear_start = 0;
   logic [1:0]    in_mode = 0;
   logic [AW-1:0] in_addr = 0;
   logic [W-1:0]  in_data = 0;
   logic readyS, readyW, validS, validW;
   logic [W-1:0] dataS, dataW;

   int nPass = 0, nTotal = 0;
   lanesT memS [NUM];
   lanesT memW [NUM];

   logic curV = 0, eV1 = 0, eV2 = 0;
   logic [W-1:0] curS = 0, curW = 0, eS1 = 0, eW1 = 0, eS2 = 0, eW2 = 0;

   psum_acc_mem #(.col(COL), .psum_bw(BW), .num(NUM), .addr_bw(AW), .sat(1)) dutS (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(readyS), .in_mode(in_mode),
      .in_addr(in_addr), .in_data(in_data), .relu_en(relu_en), .clear_start(clear_start),
      .out_valid(validS), .out_data(dataS));

   psum_acc_mem #(.col(COL), .psum_bw(BW), .num(NUM), .addr_bw(AW), .sat(0)) dutW (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(readyW), .in_mode(in_mode),
      .in_addr(in_addr), .in_data(in_data), .relu_en(relu_en), .clear_start(clear_start),
      .out_valid(validW), .out_data(dataW));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      nTotal++;
      if (got === exp) nPass++;
      else $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // Expected read results travel two cycles, and a reset drops whatever is in flight.
   always @(posedge clk) begin
      if (reset) begin
         eV1 <= 0;
         eV2 <= 0;
      end else begin
         eV1 <= curV; eS1 <= curS; eW1 <= curW;
         eV2 <= eV1;  eS2 <= eS1;  eW2 <= eW1;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("outValidS", validS, eV2);
         chk("outValidW", validW, eV2);
         if (eV2) begin
            chk("outDataS", dataS, eS2);
            chk("outDataW", dataW, eW2);
         end
      end
   end

   function automatic logic [W-1:0] pack(input lanesT v);
      logic [W-1:0] r;
      for (int k = 0; k < COL; k++) r[BW*k +: BW] = 16'(v[k]);
      return r;
   endfunction

   function automatic int fold(input int x, input bit s);
      if (s) return x > 32767 ? 32767 : (x < -32768 ? -32768 : x);
      return ((x + 32768) % 65536 + 65536) % 65536 - 32768;
   endfunction

   function automatic lanesT fill(input int v);
      lanesT r;
      for (int k = 0; k < COL; k++) r[k] = v;
      return r;
   endfunction

   function automatic lanesT rnd();
      lanesT r;
      for (int k = 0; k < COL; k++)
         r[k] = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 40)) - 20
                                          : int'($urandom_range(0, 65535)) - 32768;
      return r;
   endfunction

   task automatic issue(input logic [1:0] m, input int a, input lanesT d, input bit r, input bit clr = 0);
      lanesT oS, oW;
      @(negedge clk);
      chk("readyS", readyS, 1);
      chk("readyW", readyW, 1);
      in_valid = 1; in_mode = m; in_addr = AW'(a); in_data = pack(d); relu_en = r; clear_start = clr;
      for (int k = 0; k < COL; k++) begin
         int vS, vW;
         vS = a < NUM ? memS[a][k] : 0;
         vW = a < NUM ? memW[a][k] : 0;
         oS[k] = (r && vS < 0) ? 0 : vS;
         oW[k] = (r && vW < 0) ? 0 : vW;
         if (a < NUM) begin
            if (m == 2'b00) begin
               memS[a][k] = d[k]; memW[a][k] = d[k];
            end else if (m == 2'b01) begin
               memS[a][k] = fold(vS + d[k], 1); memW[a][k] = fold(vW + d[k], 0);
            end else if (m == 2'b11) begin
               memS[a][k] = 0; memW[a][k] = 0;
            end
         end
      end
      curV = m[1]; curS = pack(oS); curW = pack(oW);
   endtask

   task automatic step(input bit clr = 0, input bit rst = 0);
      @(negedge clk);
      in_valid = 0; clear_start = clr; reset = rst; curV = 0;
   endtask

   task automatic fillAll();
      for (int a = 0; a < NUM; a++) issue(2'b00, a, rnd(), 0);
   endtask

   task automatic readAll();
      for (int a = 0; a < NUM; a++) issue(2'b10, a, fill(0), 0);
      repeat (3) step();
   endtask

   initial begin
      lanesT d;
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("rstReadyS", readyS, 1);
      chk("rstReadyW", readyW, 1);
      chk("rstValidS", validS, 0);
      chk("rstDataS", dataS, 0);
      chk("rstDataW", dataW, 0);

      fillAll();

      d = '{1, 2, 3, 4, 5, 6, 7, 8};
      issue(2'b00, 5, d, 0);
      issue(2'b10, 5, fill(0), 1);

      issue(2'b00, 3, fill(10), 0);
      repeat (4) issue(2'b01, 3, fill(5), 0);
      issue(2'b10, 3, fill(0), 0);

      d = fill(0); d[0] = 32760;
      issue(2'b00, 7, d, 0);
      d[0] = 100;
      issue(2'b01, 7, d, 0);
      issue(2'b10, 7, fill(0), 0);
      d[0] = -32768;
      issue(2'b00, 8, d, 0);
      d[0] = -1;
      issue(2'b01, 8, d, 0);
      issue(2'b10, 8, fill(0), 0);

      d = fill(0); d[0] = -7; d[1] = 9;
      issue(2'b00, 9, d, 0);
      issue(2'b11, 9, fill(0), 1);
      issue(2'b10, 9, fill(0), 0);

      issue(2'b00, 20, fill(77), 0);
      issue(2'b01, 20, fill(1), 0);
      issue(2'b10, 20, fill(0), 0);
      issue(2'b11, 31, fill(0), 1);
      repeat (3) step();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) step();
         else issue(2'($urandom_range(0, 3)),
                    $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 19)),
                    rnd(), 1'($urandom_range(0, 1)));
      end
      repeat (3) step();

      issue(2'b10, 5, fill(0), 0);
      step(0, 1);
      step(0, 0);
      chk("dropValidS", validS, 0);
      chk("dropValidW", validW, 0);
      fillAll();

      issue(2'b00, 15, rnd(), 0, 1);
      for (int i = 1; i <= NUM + 1; i++) begin
         step(i == 3);
         chk("clrBusyS", readyS, 0);
         chk("clrBusyW", readyW, 0);
      end
      step();
      chk("clrDoneS", readyS, 1);
      chk("clrDoneW", readyW, 1);
      for (int a = 0; a < NUM; a++) begin
         memS[a] = fill(0); memW[a] = fill(0);
      end
      readAll();

      fillAll();
      issue(2'b00, 10, rnd(), 0, 1);
      for (int i = 1; i <= 5; i++) step();
      step(0, 1);
      step(0, 0);
      chk("midRstReadyS", readyS, 1);
      chk("midRstReadyW", readyW, 1);
      chk("midRstValidS", validS, 0);
      chk("midRstValidW", validW, 0);
      for (int a = 0; a < 4; a++) begin
         memS[a] = fill(0); memW[a] = fill(0);
      end
      readAll();

      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end
endmodule

// File: doc/psum_acc_mem.md
# psum_acc_mem

Parametrised partial-sum memory with built-in read-modify-write accumulation, the next generation of the core's psum SRAM path. It accepts one op per cycle, including write, accumulate, read and read-and-clear, over `col` lanes of `psum_bw`-bit signed partial sums. Back-to-back accumulates to the same address are forwarded internally. Reads can apply optional ReLU. A sequenced bulk clear zeroes the whole array. It sits between the OFIFO output and the SFP input, replacing the plain `sram_128b_w2048` psum instance.

## Interface
- `col`, 8, number of psum lanes per word
- `psum_bw`, 16, bits per lane (signed two's complement)
- `num`, 2048, memory depth in words
- `addr_bw`, 11, address width; must satisfy 2^addr_bw >= num
- `sat`, 1, 1 = saturating accumulate, 0 = wrapping accumulate

- `clk` in 1, the only clock; all state updates on its rising edge
- `reset` in 1, synchronous, active-high
- `in_valid` in 1, op request
- `in_ready` out 1, op accepted when `in_valid && in_ready`
- `in_mode` in 2, op code: 00 write, 01 accumulate, 10 read, 11 read-and-clear
- `in_addr` in addr_bw, word address; addresses >= num are ignored as no-op
- `in_data` in psum_bw*col, write/accumulate operand; lane k = bits [psum_bw*(k+1)-1 : psum_bw*k]
- `relu_en` in 1, sampled with the op; clamps negative output lanes to 0 on reads
- `clear_start` in 1, single-cycle request to zero the whole array
- `out_valid` out 1, `out_data` holds read result this cycle
- `out_data` out psum_bw*col, read result

## Operation
- Pipeline has three stages.
  - S1 (accept cycle T): op and operand are registered, and the memory read of `in_addr` is issued.
  - S2 (T+1): memory data is available and the new value is computed.
    - write: `in_data`.
    - accumulate: old + `in_data`, per lane.
    - read: unchanged, no write.
    - read-and-clear: 0.
  - Memory is written at the end of T+1.
  - S3 (T+2): read result is registered onto `out_data`.
- Forwarding: if the S2 op reads the address the previous cycle's S2 op wrote, the previous written value is used instead of the memory Q. One-deep forwarding covers all hazards because every write commits in S2 in program order.
- Accumulate arithmetic:
  - Each lane is a signed psum_bw+1-bit sum.
  - With `sat`=1, results clamp to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - With `sat`=0, results are truncated to psum_bw bits.
- ReLU applies to `out_data` only and never to stored values.
- Clear FSM has states IDLE → DRAIN → CLEAR → IDLE.
  - `clear_start` is honoured only in IDLE and ignored otherwise.
  - DRAIN lasts 1 cycle and lets an in-flight op commit.
  - CLEAR writes 0 to addresses 0..num-1, one per cycle, via a counter.
  - CLEAR returns to IDLE after address num-1 is written.
- `in_ready` = (state == IDLE).
  - An op and `clear_start` in the same IDLE cycle: the op is accepted and completes before the clear.
- Memory contents are not reset; only control state is reset.

## Timing
- Reset values:
  - `in_ready` 1.
  - `out_valid` 0.
  - `out_data` 0.
  - FSM in IDLE, clear counter 0, all pipeline valids 0.
- Read latency is 2: an op accepted at cycle T gives `out_valid`=1 with data at T+2 for 1 cycle. Write and accumulate ops produce no `out_valid`.
- Throughput is 1 op/cycle in IDLE, with no bubbles for same-address sequences.
- Clear timing, for `clear_start` at cycle C:
  - `in_ready` is 0 from C+1 through C+1+num.
  - Zero writes occur at C+2..C+1+num.
  - `in_ready` returns to 1 at C+2+num.
- Reset mid-clear or mid-pipeline:
  - Next cycle goes to IDLE; pending ops are dropped and `out_valid` is 0.
  - Partially cleared contents are left as-is.
- Out-of-range address:
  - Accepted and consumes a slot.
  - No write is performed.
  - Read returns `out_valid`=1 with `out_data`=0.

## Test plan
- Write, then read-back: col=8, psum_bw=16. Write addr 5 with lanes 1..8, then read addr 5 one cycle later. Expect `out_valid` at read+2 with lanes 1..8, and ReLU has no effect.
- Back-to-back accumulate hazard: write addr 3 with all lanes 10, then accumulate addr 3 +5 on 4 consecutive cycles, then read. Expect 30 in every lane, which proves forwarding.
- Saturation: lane 0 = 32760, accumulate +100. With `sat`=1 the read gives 32767. With `sat`=0 it gives -32676. With -32768 + (-1) and `sat`=1 the result is -32768.
- ReLU and read-and-clear:
  - Store lanes -7 and 9, then read-and-clear with `relu_en`=1. Output is 0 and 9.
  - A following read without ReLU gives 0 and 0.
- Bulk clear, num=16:
  - Fill all addresses, pulse `clear_start` at C with a concurrent write to addr 15.
  - `in_ready` is low C+1..C+17.
  - All reads after return 0, including addr 15.
- Reset mid-clear: reset at C+6 gives `in_ready`=1 and `out_valid`=0 next cycle. Addresses 0..3 read 0 and addresses 4..15 retain old data.
